// File: rtl/apb_pkg.sv
// Shared APB definitions for the two-master arbiter: FSM states, psel target
// encodings and default bus widths.
package apb_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    localparam logic [1:0] PSEL_IDLE = 2'b00;
    localparam logic [1:0] PSEL_RM   = 2'b01;
    localparam logic [1:0] PSEL_ICN  = 2'b10;
    localparam logic [1:0] PSEL_BAD  = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: a contested cycle goes to the master
// that was not served last; a lone requester always wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_gnt ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/apb_bus_arbiter.sv
// Two-master APB arbiter in front of the secure access FSM: serialises transfers
// round-robin, routes each response back to its owner and aborts hung accesses.
module apb_bus_arbiter
    import apb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        m0_psel,
    input  logic              m0_penable,
    input  logic              m0_pwrite,
    input  logic [1:0]        m0_pstrb,
    input  logic [ADDR_W-1:0] m0_paddr,
    input  logic [DATA_W-1:0] m0_pwdata,
    output logic [DATA_W-1:0] m0_prdata,
    output logic              m0_pready,
    output logic              m0_pslverr,
    input  logic [1:0]        m1_psel,
    input  logic              m1_penable,
    input  logic              m1_pwrite,
    input  logic [1:0]        m1_pstrb,
    input  logic [ADDR_W-1:0] m1_paddr,
    input  logic [DATA_W-1:0] m1_pwdata,
    output logic [DATA_W-1:0] m1_prdata,
    output logic              m1_pready,
    output logic              m1_pslverr,
    output logic [1:0]        s_psel,
    output logic              s_penable,
    output logic              s_pwrite,
    output logic [1:0]        s_pstrb,
    output logic [ADDR_W-1:0] s_paddr,
    output logic [DATA_W-1:0] s_pwdata,
    input  logic [DATA_W-1:0] s_prdata,
    input  logic              s_pready,
    input  logic              s_pslverr_rm,
    input  logic              s_pslverr_icn,
    output logic [1:0]        gnt,
    output logic              timeout_evt
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W:0] TO_LIMIT = TIMEOUT_CYC[CNT_W:0];

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CNT_W:0]    cnt_inc;
    logic              timeout_hit;
    logic              last_gnt, last_gnt_nxt;
    logic [1:0]        gnt_nxt, pick, req;
    logic              win_sel;
    logic [1:0]        win_psel;

    logic [1:0]        s_psel_nxt, s_pstrb_nxt;
    logic              s_penable_nxt, s_pwrite_nxt;
    logic [ADDR_W-1:0] s_paddr_nxt;
    logic [DATA_W-1:0] s_pwdata_nxt;

    logic              rsp_valid, rsp_err, rsp_owner, timeout_evt_nxt;
    logic [DATA_W-1:0] rsp_data;

    // The masters' own penable is not trusted; the forwarded one is generated here.
    logic unused_penable;
    assign unused_penable = m0_penable ^ m1_penable;

    assign req      = {m1_psel != PSEL_IDLE, m0_psel != PSEL_IDLE};
    assign win_sel  = pick[1];
    assign win_psel = win_sel ? m1_psel : m0_psel;

    assign cnt_inc     = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_inc == TO_LIMIT);

    rr_arb2 u_rr_arb2 (
        .req      (req),
        .last_gnt (last_gnt),
        .gnt      (pick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            last_gnt    <= 1'b1;
            gnt         <= 2'b00;
            s_psel      <= 2'b00;
            s_penable   <= 1'b0;
            s_pwrite    <= 1'b0;
            s_pstrb     <= 2'b00;
            s_paddr     <= '0;
            s_pwdata    <= '0;
            m0_pready   <= 1'b0;
            m0_pslverr  <= 1'b0;
            m0_prdata   <= '0;
            m1_pready   <= 1'b0;
            m1_pslverr  <= 1'b0;
            m1_prdata   <= '0;
            timeout_evt <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            last_gnt    <= last_gnt_nxt;
            gnt         <= gnt_nxt;
            s_psel      <= s_psel_nxt;
            s_penable   <= s_penable_nxt;
            s_pwrite    <= s_pwrite_nxt;
            s_pstrb     <= s_pstrb_nxt;
            s_paddr     <= s_paddr_nxt;
            s_pwdata    <= s_pwdata_nxt;
            m0_pready   <= rsp_valid && !rsp_owner;
            m0_pslverr  <= rsp_valid && !rsp_owner && rsp_err;
            m0_prdata   <= (rsp_valid && !rsp_owner) ? rsp_data : '0;
            m1_pready   <= rsp_valid && rsp_owner;
            m1_pslverr  <= rsp_valid && rsp_owner && rsp_err;
            m1_prdata   <= (rsp_valid && rsp_owner) ? rsp_data : '0;
            timeout_evt <= timeout_evt_nxt;
        end
    end

    // An illegal target select is answered directly without touching the slave.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick != 2'b00) begin
                    state_nxt = (win_psel == PSEL_BAD) ? RESP : SETUP;
                end
            end
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (s_pready || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt         = cnt;
        last_gnt_nxt    = last_gnt;
        gnt_nxt         = gnt;
        s_psel_nxt      = s_psel;
        s_penable_nxt   = s_penable;
        s_pwrite_nxt    = s_pwrite;
        s_pstrb_nxt     = s_pstrb;
        s_paddr_nxt     = s_paddr;
        s_pwdata_nxt    = s_pwdata;
        rsp_valid       = 1'b0;
        rsp_err         = 1'b0;
        rsp_data        = '0;
        rsp_owner       = gnt[1];
        timeout_evt_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (pick != 2'b00) begin
                    gnt_nxt   = pick;
                    rsp_owner = win_sel;
                    if (win_psel == PSEL_BAD) begin
                        rsp_valid = 1'b1;
                        rsp_err   = 1'b1;
                    end else begin
                        s_psel_nxt    = win_psel;
                        s_penable_nxt = 1'b0;
                        s_pwrite_nxt  = win_sel ? m1_pwrite : m0_pwrite;
                        s_pstrb_nxt   = win_sel ? m1_pstrb  : m0_pstrb;
                        s_paddr_nxt   = win_sel ? m1_paddr  : m0_paddr;
                        s_pwdata_nxt  = win_sel ? m1_pwdata : m0_pwdata;
                    end
                end
            end
            SETUP: begin
                s_penable_nxt = 1'b1;
                cnt_nxt       = '0;
            end
            ACCESS: begin
                cnt_nxt = cnt_inc[CNT_W-1:0];
                if (s_pready || timeout_hit) begin
                    rsp_valid     = 1'b1;
                    s_psel_nxt    = 2'b00;
                    s_penable_nxt = 1'b0;
                    s_pwrite_nxt  = 1'b0;
                    s_pstrb_nxt   = 2'b00;
                    s_paddr_nxt   = '0;
                    s_pwdata_nxt  = '0;
                    if (s_pready) begin
                        rsp_data = s_prdata;
                        rsp_err  = (s_psel == PSEL_RM) ? s_pslverr_rm : s_pslverr_icn;
                    end else begin
                        rsp_err         = 1'b1;
                        timeout_evt_nxt = 1'b1;
                    end
                end
            end
            RESP: begin
                gnt_nxt      = 2'b00;
                last_gnt_nxt = gnt[1];
                cnt_nxt      = '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Self-checking bench for apb_bus_arbiter: directed scenarios plus random rounds
// checked against a transaction-level model of arbitration order and responses.
module tb_apb_bus_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    m0_psel, m1_psel;
    logic          m0_penable, m1_penable, m0_pwrite, m1_pwrite;
    logic [1:0]    m0_pstrb, m1_pstrb;
    logic [AW-1:0] m0_paddr, m1_paddr;
    logic [DW-1:0] m0_pwdata, m1_pwdata, m0_prdata, m1_prdata;
    logic          m0_pready, m1_pready, m0_pslverr, m1_pslverr;
    logic [1:0]    s_psel, s_pstrb, gnt;
    logic          s_penable, s_pwrite, s_pready, s_pslverr_rm, s_pslverr_icn, timeout_evt;
    logic [AW-1:0] s_paddr;
    logic [DW-1:0] s_pwdata, s_prdata;

    int total = 0;
    int bad   = 0;

    logic          active  [2];
    logic [1:0]    t_psel  [2];
    logic          t_write [2];
    logic [1:0]    t_strb  [2];
    logic [AW-1:0] t_addr  [2];
    logic [DW-1:0] t_wdata [2];
    logic [DW-1:0] t_rdata [2];
    logic          t_erm   [2];
    logic          t_eicn  [2];
    int            t_k     [2];
    int            reissue [2];
    int            last_served;

    always #5 clk = ~clk;

    apb_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
        .m0_pstrb(m0_pstrb), .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata),
        .m0_prdata(m0_prdata), .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
        .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
        .m1_pstrb(m1_pstrb), .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata),
        .m1_prdata(m1_prdata), .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_pstrb(s_pstrb), .s_paddr(s_paddr), .s_pwdata(s_pwdata),
        .s_prdata(s_prdata), .s_pready(s_pready),
        .s_pslverr_rm(s_pslverr_rm), .s_pslverr_icn(s_pslverr_icn),
        .gnt(gnt), .timeout_evt(timeout_evt)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_output({tag, " slave_side"}, {10'd0, s_psel, s_penable, s_pwrite, s_pstrb, s_pwdata}, 32'd0);
        check_output({tag, " slave_addr"}, {12'd0, s_paddr}, 32'd0);
        check_output({tag, " ctrl"}, {m0_pready, m0_pslverr, m1_pready, m1_pslverr, gnt, timeout_evt}, 32'd0);
        check_output({tag, " rdata"}, {m0_prdata, m1_prdata}, 32'd0);
    endtask

    task automatic apply_stimulus();
        m0_psel    = active[0] ? t_psel[0] : 2'b00;
        m0_penable = active[0];
        m0_pwrite  = t_write[0];
        m0_pstrb   = t_strb[0];
        m0_paddr   = t_addr[0];
        m0_pwdata  = t_wdata[0];
        m1_psel    = active[1] ? t_psel[1] : 2'b00;
        m1_penable = active[1];
        m1_pwrite  = t_write[1];
        m1_pstrb   = t_strb[1];
        m1_paddr   = t_addr[1];
        m1_pwdata  = t_wdata[1];
    endtask

    task automatic set_txn(input int m, input logic [1:0] psel, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                           input logic erm, input logic eicn, input int k);
        active[m]  = 1'b1;
        t_psel[m]  = psel;
        t_write[m] = wr;
        t_strb[m]  = 2'b11;
        t_addr[m]  = addr;
        t_wdata[m] = wdata;
        t_rdata[m] = rdata;
        t_erm[m]   = erm;
        t_eicn[m]  = eicn;
        t_k[m]     = k;
    endtask

    task automatic random_txn(input int m);
        logic [1:0] ps;
        if ($urandom_range(0, 7) == 0) ps = 2'b11;
        else ps = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
        set_txn(m, ps, 1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
                1'($urandom), 1'($urandom), $urandom_range(0, 5));
        t_strb[m] = 2'($urandom);
    endtask

    // Runs all launched (and re-issued) transfers to completion, checking order and responses.
    task automatic run_round(input string tag);
        int cyc = 0, cur = -1, grant_cyc = 0, acc = 0, last_done = 0, exp_owner, exp_lat;
        bit first = 1'b1;
        logic exp_err, exp_to;
        logic [DW-1:0] exp_data;
        apply_stimulus();
        while ((active[0] || active[1] || cur >= 0) && cyc < 300) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (cur < 0 && gnt !== 2'b00) begin
                exp_owner = (active[0] && active[1]) ? 1 - last_served : (active[1] ? 1 : 0);
                check_output({tag, " gnt"}, {30'd0, gnt}, (exp_owner == 1) ? 32'd2 : 32'd1);
                check_output({tag, " grant_time"}, cyc, first ? 1 : last_done + 2);
                first     = 1'b0;
                cur       = exp_owner;
                grant_cyc = cyc;
                acc       = 0;
                if (t_psel[cur] == 2'b11) begin
                    check_output({tag, " no_slave_sel"}, {30'd0, s_psel}, 32'd0);
                end else begin
                    check_output({tag, " setup_ctrl"}, {s_psel, s_penable, s_pwrite, s_pstrb},
                                 {t_psel[cur], 1'b0, t_write[cur], t_strb[cur]});
                    check_output({tag, " setup_addr"}, s_paddr, t_addr[cur]);
                    check_output({tag, " setup_wdata"}, s_pwdata, t_wdata[cur]);
                end
            end
            if (cur >= 0 && (m0_pready === 1'b1 || m1_pready === 1'b1)) begin
                if (t_psel[cur] == 2'b11) begin
                    exp_err = 1'b1; exp_data = '0; exp_to = 1'b0; exp_lat = 0;
                end else if (t_k[cur] >= TO) begin
                    exp_err = 1'b1; exp_data = '0; exp_to = 1'b1; exp_lat = 1 + TO;
                end else begin
                    exp_err  = (t_psel[cur] == 2'b01) ? t_erm[cur] : t_eicn[cur];
                    exp_data = t_rdata[cur];
                    exp_to   = 1'b0;
                    exp_lat  = 2 + t_k[cur];
                end
                if (cur == 0) begin
                    check_output({tag, " m0_rsp"}, {m0_pready, m0_pslverr, m0_prdata}, {1'b1, exp_err, exp_data});
                    check_output({tag, " m1_quiet"}, {m1_pready, m1_pslverr, m1_prdata}, 32'd0);
                end else begin
                    check_output({tag, " m1_rsp"}, {m1_pready, m1_pslverr, m1_prdata}, {1'b1, exp_err, exp_data});
                    check_output({tag, " m0_quiet"}, {m0_pready, m0_pslverr, m0_prdata}, 32'd0);
                end
                check_output({tag, " timeout_evt"}, {31'd0, timeout_evt}, {31'd0, exp_to});
                check_output({tag, " slave_released"}, {29'd0, s_psel, s_penable}, 32'd0);
                check_output({tag, " latency"}, cyc - grant_cyc, exp_lat);
                last_served = cur;
                last_done   = cyc;
                active[cur] = 1'b0;
                if (reissue[cur] > 0) begin
                    reissue[cur]--;
                    random_txn(cur);
                end
                cur = -1;
                apply_stimulus();
            end
            s_pready      = 1'b0;
            s_prdata      = (cur >= 0) ? t_rdata[cur] : DW'($urandom);
            s_pslverr_rm  = (cur >= 0) ? t_erm[cur]  : 1'b0;
            s_pslverr_icn = (cur >= 0) ? t_eicn[cur] : 1'b0;
            if (cur >= 0 && s_penable === 1'b1) begin
                acc++;
                if (acc - 1 == t_k[cur]) s_pready = 1'b1;
            end
        end
        if (active[0] || active[1] || cur >= 0) begin
            check_output({tag, " hung"}, {30'd0, active[1], active[0]}, 32'd0);
        end
        s_pready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output({tag, " gnt_released"}, {30'd0, gnt}, 32'd0);
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            set_txn(m, 2'b00, 1'b0, '0, '0, '0, 1'b0, 1'b0, 0);
            active[m]  = 1'b0;
            reissue[m] = 0;
        end
        last_served   = 1;
        reset_n       = 1'b0;
        s_pready      = 1'b0;
        s_prdata      = '0;
        s_pslverr_rm  = 1'b0;
        s_pslverr_icn = 1'b0;
        apply_stimulus();
        repeat (2) @(negedge clk);
        check_quiet("reset");
        reset_n = 1'b1;

        // Simultaneous requests right after reset: master 0 goes first.
        set_txn(0, 2'b01, 1'b1, 20'h00100, 16'hA5A5, 16'h1111, 1'b0, 1'b1, 0);
        set_txn(1, 2'b10, 1'b0, 20'h00200, 16'h5A5A, 16'h2222, 1'b1, 1'b0, 1);
        run_round("both_after_reset");

        set_txn(0, 2'b01, 1'b1, 20'h00010, 16'h1234, 16'h0000, 1'b0, 1'b0, 1);
        run_round("m0_write_rm");

        set_txn(1, 2'b10, 1'b0, 20'h00C1A, 16'h0000, 16'hBEEF, 1'b0, 1'b1, 0);
        run_round("m1_read_icn_err");
        set_txn(1, 2'b10, 1'b0, 20'h00C1A, 16'h0000, 16'hCAFE, 1'b1, 1'b0, 2);
        run_round("m1_read_icn_rm_ignored");
        set_txn(0, 2'b01, 1'b0, 20'h00044, 16'h0000, 16'h7777, 1'b1, 1'b0, 3);
        run_round("m0_rm_err_late");

        set_txn(0, 2'b01, 1'b0, 20'h00020, 16'h0000, 16'hDEAD, 1'b0, 1'b0, 5);
        run_round("m0_timeout");

        set_txn(0, 2'b11, 1'b1, 20'h00030, 16'h4321, 16'hFFFF, 1'b0, 1'b0, 0);
        run_round("m0_illegal_psel");

        // Both masters keep requesting; grants must alternate.
        random_txn(0);
        random_txn(1);
        reissue[0] = 2;
        reissue[1] = 2;
        run_round("held_alternate");

        // Asynchronous reset in the middle of an access.
        set_txn(0, 2'b01, 1'b1, 20'h00050, 16'h9999, 16'h0000, 1'b0, 1'b0, 5);
        apply_stimulus();
        for (int i = 0; i < 20 && s_penable !== 1'b1; i++) @(negedge clk);
        check_output("mid_access_reached", {31'd0, s_penable}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_quiet("reset_mid_access");
        active[0] = 1'b0;
        apply_stimulus();
        @(negedge clk);
        reset_n     = 1'b1;
        last_served = 1;
        set_txn(1, 2'b10, 1'b0, 20'h00060, 16'h0000, 16'h3C3C, 1'b0, 1'b0, 0);
        run_round("m1_after_reset");

        for (int r = 0; r < 40; r++) begin
            int pat = $urandom_range(1, 3);
            for (int m = 0; m < 2; m++) begin
                if (pat[m]) begin
                    random_txn(m);
                    reissue[m] = $urandom_range(0, 2);
                end
            end
            run_round("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
